// File: rtl/vscale_hasti_arbiter_pkg.sv
// Shared HASTI widths, transfer/response codes and data-phase owner encoding
// for the two-master arbiter slice.
package vscale_hasti_arbiter_pkg;

  localparam int ADDR_WIDTH  = 32;
  localparam int BUS_WIDTH   = 32;
  localparam int SIZE_WIDTH  = 3;
  localparam int BURST_WIDTH = 3;
  localparam int PROT_WIDTH  = 4;
  localparam int TRANS_WIDTH = 2;

  localparam logic [TRANS_WIDTH-1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [TRANS_WIDTH-1:0] HTRANS_NONSEQ = 2'd2;

  localparam logic HRESP_OKAY = 1'b0;

  typedef enum logic [1:0] {
    HASTI_OWN_NONE = 2'd0,
    HASTI_OWN_M0   = 2'd1,
    HASTI_OWN_M1   = 2'd2
  } hasti_own_e;

  function automatic hasti_own_e own_of(input logic [1:0] gnt);
    case (gnt)
      2'b01:   own_of = HASTI_OWN_M0;
      2'b10:   own_of = HASTI_OWN_M1;
      default: own_of = HASTI_OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/vscale_hasti_rr_pick.sv
// Two-way round-robin picker: a held (pending) request always wins, otherwise
// a tie goes to the master that was not granted last.
module vscale_hasti_rr_pick (
  input  logic [1:0] req_i,
  input  logic [1:0] pend_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // Priority: pending master, then single requester, then alternate on tie
  always_comb begin
    gnt_o = 2'b00;
    if (pend_i[0]) begin
      gnt_o = 2'b01;
    end else if (pend_i[1]) begin
      gnt_o = 2'b10;
    end else begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/vscale_hasti_arbiter.sv
// Two-master to one-slave HASTI arbiter with zero-latency forwarding, loser
// stalling and buffering of a loser's completed read data.
module vscale_hasti_arbiter
  import vscale_hasti_arbiter_pkg::*;
#(
  parameter logic FIRST_GRANT = 1'b0
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [ADDR_WIDTH-1:0]  m0_haddr,
  input  logic                   m0_hwrite,
  input  logic [SIZE_WIDTH-1:0]  m0_hsize,
  input  logic [BURST_WIDTH-1:0] m0_hburst,
  input  logic                   m0_hmastlock,
  input  logic [PROT_WIDTH-1:0]  m0_hprot,
  input  logic [TRANS_WIDTH-1:0] m0_htrans,
  input  logic [BUS_WIDTH-1:0]   m0_hwdata,
  output logic [BUS_WIDTH-1:0]   m0_hrdata,
  output logic                   m0_hready,
  output logic                   m0_hresp,
  input  logic [ADDR_WIDTH-1:0]  m1_haddr,
  input  logic                   m1_hwrite,
  input  logic [SIZE_WIDTH-1:0]  m1_hsize,
  input  logic [BURST_WIDTH-1:0] m1_hburst,
  input  logic                   m1_hmastlock,
  input  logic [PROT_WIDTH-1:0]  m1_hprot,
  input  logic [TRANS_WIDTH-1:0] m1_htrans,
  input  logic [BUS_WIDTH-1:0]   m1_hwdata,
  output logic [BUS_WIDTH-1:0]   m1_hrdata,
  output logic                   m1_hready,
  output logic                   m1_hresp,
  output logic [ADDR_WIDTH-1:0]  s_haddr,
  output logic                   s_hwrite,
  output logic [SIZE_WIDTH-1:0]  s_hsize,
  output logic [BURST_WIDTH-1:0] s_hburst,
  output logic                   s_hmastlock,
  output logic [PROT_WIDTH-1:0]  s_hprot,
  output logic [TRANS_WIDTH-1:0] s_htrans,
  output logic [BUS_WIDTH-1:0]   s_hwdata,
  input  logic [BUS_WIDTH-1:0]   s_hrdata,
  input  logic                   s_hready,
  input  logic                   s_hresp
);

  logic [1:0]                pend_q, pend_d;
  logic                      last_q, last_d;
  hasti_own_e                d_own_q, d_own_d;
  logic                      d_write_q, d_write_d;
  logic [1:0][BUS_WIDTH-1:0] rbuf_q, rbuf_d;
  logic [1:0]                rbv_q, rbv_d;

  logic [1:0] req_s, pick_s, gnt_s, lose_s, hready_s, own_is_s;
  logic       any_gnt_s, sel_m1_s;

  assign req_s = {m1_htrans != HTRANS_IDLE, m0_htrans != HTRANS_IDLE};

  vscale_hasti_rr_pick u_pick (
    .req_i  (req_s),
    .pend_i (pend_q),
    .last_i (last_q),
    .gnt_o  (pick_s)
  );

  // Grants only exist while the slave can accept an address phase
  assign gnt_s     = (s_hready && !hreset) ? pick_s : 2'b00;
  assign lose_s    = req_s & ~gnt_s;
  assign any_gnt_s = |gnt_s;
  assign sel_m1_s  = gnt_s[1];
  assign own_is_s  = {d_own_q == HASTI_OWN_M1, d_own_q == HASTI_OWN_M0};
  assign hready_s  = {2{hreset}} | ({2{s_hready}} & ~lose_s);

  assign s_haddr     = sel_m1_s ? m1_haddr     : m0_haddr;
  assign s_hwrite    = sel_m1_s ? m1_hwrite    : m0_hwrite;
  assign s_hsize     = sel_m1_s ? m1_hsize     : m0_hsize;
  assign s_hburst    = sel_m1_s ? m1_hburst    : m0_hburst;
  assign s_hmastlock = sel_m1_s ? m1_hmastlock : m0_hmastlock;
  assign s_hprot     = sel_m1_s ? m1_hprot     : m0_hprot;
  assign s_htrans    = any_gnt_s ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign s_hwdata    = own_is_s[1] ? m1_hwdata : m0_hwdata;

  assign m0_hready = hready_s[0];
  assign m1_hready = hready_s[1];
  assign m0_hresp  = own_is_s[0] ? s_hresp : HRESP_OKAY;
  assign m1_hresp  = own_is_s[1] ? s_hresp : HRESP_OKAY;
  assign m0_hrdata = own_is_s[0] ? s_hrdata : (rbv_q[0] ? rbuf_q[0] : {BUS_WIDTH{1'b0}});
  assign m1_hrdata = own_is_s[1] ? s_hrdata : (rbv_q[1] ? rbuf_q[1] : {BUS_WIDTH{1'b0}});

  // Next-state: everything advances only on a completed slave cycle
  always_comb begin
    pend_d    = pend_q;
    last_d    = last_q;
    d_own_d   = d_own_q;
    d_write_d = d_write_q;
    rbuf_d    = rbuf_q;
    rbv_d     = rbv_q;
    if (s_hready) begin
      pend_d    = lose_s;
      d_own_d   = own_of(gnt_s);
      d_write_d = any_gnt_s & (sel_m1_s ? m1_hwrite : m0_hwrite);
      if (any_gnt_s) begin
        last_d = sel_m1_s;
      end else begin
        last_d = last_q;
      end
      for (int n = 0; n < 2; n++) begin
        // Stalled master's read finished at the slave: keep it for later
        if (lose_s[n] && own_is_s[n] && !d_write_q) begin
          rbuf_d[n] = s_hrdata;
          rbv_d[n]  = 1'b1;
        end else if (hready_s[n] && rbv_q[n]) begin
          rbv_d[n] = 1'b0;
        end else begin
          rbv_d[n] = rbv_q[n];
        end
      end
    end else begin
      pend_d = pend_q;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      pend_q    <= 2'b00;
      last_q    <= ~FIRST_GRANT;
      d_own_q   <= HASTI_OWN_NONE;
      d_write_q <= 1'b0;
      rbuf_q    <= '0;
      rbv_q     <= 2'b00;
    end else begin
      pend_q    <= pend_d;
      last_q    <= last_d;
      d_own_q   <= d_own_d;
      d_write_q <= d_write_d;
      rbuf_q    <= rbuf_d;
      rbv_q     <= rbv_d;
    end
  end

endmodule
